// File: rtl/mul18_rr_arbiter.sv
// mul18_rr_arbiter
//   Shares one external pipelined signed multiplier (LAT ce-gated register
//   stages, no reset) among NUM_REQ requesters. Grants round-robin, carries
//   the requester ID alongside the multiplier pipeline and returns each
//   product to its owner. Output backpressure stalls the multiplier via ce.
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or zero)
//   req_a/req_b            packed operands, slice i belongs to requester i
//   mul_ce/din0/din1       multiplier drive (combinational)
//   mul_dout               multiplier product
//   rsp_valid/rsp_data     one-hot product valid, broadcast product
//   rsp_ready              shared response accept
//   busy                   any pipeline tag valid
//
// Optional build macro MUL18_RR_ARBITER_STATS_EN adds grant_cnt and
// stall_cnt (32-bit wrapping event counters).
module mul18_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 18,
    parameter int unsigned PW      = 36,
    parameter int unsigned LAT     = 2,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic                  mul_ce,
    output logic [DW-1:0]         mul_din0,
    output logic [DW-1:0]         mul_din1,
    input  logic [PW-1:0]         mul_dout,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [PW-1:0]         rsp_data,
    input  logic                  rsp_ready,
    output logic                  busy
`ifdef MUL18_RR_ARBITER_STATS_EN
    ,
    output logic [31:0]           grant_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    logic [IDW-1:0]           ptr_q, ptr_d;
    logic [LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;

    logic                     win_found;
    logic [IDW-1:0]           win_idx;
    logic                     accept;
    int unsigned              cand;

    // Whole pipe (tags and multiplier) advances unless a product is stuck at the output.
    assign mul_ce = !tag_vld_q[LAT-1] || rsp_ready;

    // Round-robin pick: first valid requester at or above ptr, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[IDW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    assign accept    = win_found && mul_ce;
    assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;

    // Operands follow the pick even while stalled; the multiplier ignores them then.
    assign mul_din0 = req_a[win_idx*DW +: DW];
    assign mul_din1 = req_b[win_idx*DW +: DW];

    // Next pointer and tag pipeline; bubbles enter as valid=0.
    always_comb begin
        ptr_d     = ptr_q;
        tag_vld_d = tag_vld_q;
        tag_id_d  = tag_id_q;
        if (accept) begin
            ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDW'(1);
        end
        if (mul_ce) begin
            tag_vld_d[0] = accept;
            tag_id_d[0]  = win_idx;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_id_d[i]  = tag_id_q[i-1];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    // Output stage decode; held while stalled because the tags are frozen.
    assign rsp_valid = tag_vld_q[LAT-1] ? (NUM_REQ'(1) << tag_id_q[LAT-1]) : '0;
    assign rsp_data  = mul_dout;
    assign busy      = |tag_vld_q;

`ifdef MUL18_RR_ARBITER_STATS_EN
    logic [31:0] grant_cnt_q;
    logic [31:0] stall_cnt_q;

    // Event counters: accepted grants and output-stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                grant_cnt_q <= grant_cnt_q + 32'd1;
            end
            if (!mul_ce && tag_vld_q[LAT-1]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/mul18_rr_arbiter.md
Name: mul18_rr_arbiter

Overview:
- Shares one pipelined 18x18 signed multiplier (2 register stages, ce-gated, no reset) among NUM_REQ requesters in the MLP datapath.
- Grants round-robin and drives the multiplier's ce/din0/din1.
- Tracks requester ID through the pipeline and returns each product to its owner.
- Applies output backpressure by stalling the multiplier through ce.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 18, operand width (signed).
- PW, 36, product width (2*DW).
- LAT, 2, multiplier pipeline depth in ce-enabled cycles.
- IDW, 2, requester-ID width (clog2(NUM_REQ)).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester operand valid.
- req_ready, out, NUM_REQ, per-requester grant (one-hot or zero).
- req_a, in, NUM_REQ*DW, packed operand A; slice i belongs to requester i.
- req_b, in, NUM_REQ*DW, packed operand B.
- mul_ce, out, 1, multiplier clock enable.
- mul_din0, out, DW, multiplier operand A.
- mul_din1, out, DW, multiplier operand B.
- mul_dout, in, PW, multiplier product.
- rsp_valid, out, NUM_REQ, one-hot product-valid for the owning requester.
- rsp_data, out, PW, product (same value broadcast to all requesters).
- rsp_ready, in, 1, shared response accept.
- busy, out, 1, high while any pipeline tag is valid.

Behaviour:
- Reset (reset=0, async): tag valids clear, RR pointer=0. Resulting outputs: rsp_valid=0, req_ready=0, busy=0.
- Multiplier regs have no reset. Garbage in them is masked because all tag valids are cleared.
- Tag pipeline: LAT stages of {valid, id}, all advancing only when mul_ce=1. Stage LAT is the output stage.
- mul_ce = !tag_valid[LAT] || rsp_ready (combinational).
- Arbitration, combinational, only when mul_ce=1:
  - Pick the first i with req_valid[i], searching from ptr upward with wrap.
  - req_ready[i]=1 for the winner; mul_din0/din1 = req_a/req_b slice i.
  - The request is accepted on the edge where req_valid[i]&req_ready[i].
- When mul_ce=0, req_ready=0. mul_din0/din1 still follow the pick, but they are don't-care.
- Pointer update: on acceptance of i, ptr <= (i+1) mod NUM_REQ. Otherwise ptr holds.
- Stage-1 tag: on a ce edge, stage1.valid <= (accept this cycle), stage1.id <= winner. Bubbles propagate as valid=0.
- Latency: accept at edge E produces rsp_valid[id]=1 in the cycle after edge E+LAT-1 (LAT ce-edges later), i.e. 2 cycles when there is no stall.
- rsp_valid = onehot(tag[LAT].id) & {NUM_REQ{tag[LAT].valid}}. rsp_data = mul_dout. Both are held stable while rsp_ready=0.
- Stall: rsp_valid asserted with rsp_ready=0 gives ce=0, so the whole pipe and the multiplier freeze and no new grant is issued.
- Full throughput: 1 product per cycle when rsp_ready=1 continuously.
- Simultaneous events: response accept and new grant in the same cycle are allowed, because ce=1.
- Reset mid-operation drops in-flight products; no rsp_valid after reset release until a new accept completes.
- busy = OR of all tag valids.
- Arithmetic is performed by the multiplier. Products are signed, full PW, no truncation or saturation.

Optional Feature:
- Macro: MUL18_RR_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_cnt (32b): counts accepted requests, wraps at 2^32.
  - Adds output stall_cnt (32b): counts cycles with mul_ce=0 and tag[LAT].valid=1.
  - Both counters reset to 0 on reset.
- When undefined: neither port nor counter exists; functional behaviour is identical.

Test Plan:
- Single request: req0 a=3, b=-5, rsp_ready=1 → req_ready[0] in cycle 0; rsp_valid=0001 and rsp_data=-15 exactly 2 cycles later; busy=0 afterwards.
- All 4 requesting continuously with a=i+1, b=10, rsp_ready=1:
  - Grant order 0,1,2,3,0…; one response per cycle.
  - rsp_data sequence 10,20,30,40; ids match the one-hot.
- Backpressure: 3 back-to-back requests, then rsp_ready=0 for 5 cycles after the first rsp_valid:
  - rsp_valid/rsp_data hold, mul_ce=0, req_ready=0.
  - On release, the remaining products emerge in order with no loss or duplication.
- Extremes: a=-131072, b=-131072 → rsp_data=17179869184; a=131071, b=-131072 → -17179738112.
- Async reset asserted mid-flight with 2 tags valid → rsp_valid=0 and busy=0 immediately; ptr restarts at 0; no stale response after reset release.
- With MUL18_RR_ARBITER_STATS_EN: backpressure scenario → grant_cnt=3, stall_cnt=5.
